// File: rtl/trisc_useq.sv
// trisc_useq: microprogram sequencer with call stack; counted loops enabled by TRISC_USEQ_LOOP_EN
module trisc_useq #(
  parameter int AW = 6,
  parameter int OW = 28,
  parameter int NCS = 3,
  parameter int SD = 4,
  parameter int CNTW = 6,
  parameter int CW = 2 ** NCS - 1,
  parameter int MW = OW + 3 + NCS + 1 + AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] cond,
  input  logic          hold,
  output logic [AW-1:0] rom_addr,
  input  logic [MW-1:0] rom_data,
  output logic [OW-1:0] out_sig,
  output logic          halted,
  output logic          stk_err
);
  localparam int SPW = $clog2(SD + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(SD);
  logic [AW-1:0] upc, upc_inc, upc_nxt, tgt;
  logic [OW-1:0] ctrl;
  logic [2:0] op;
  logic [NCS-1:0] csel, cidx;
  logic cpol, t, run, push, pop, err, loop_take;
  logic [SPW-1:0] sp;
  logic [AW-1:0] stk [2 ** SPW];
  assign {ctrl, op, csel, cpol, tgt} = rom_data;
  assign cidx = csel - NCS'(1);
  assign t = ((csel == '0) ? 1'b1 : cond[cidx]) ^ cpol;
  assign upc_inc = upc + AW'(1);
  assign run = !hold && !halted;
  assign rom_addr = upc;
`ifdef TRISC_USEQ_LOOP_EN
  logic [CNTW-1:0] cnt;
  assign loop_take = op == 3'd6 && cnt != '0;
  // loop counter: loaded by LDCNT, decremented by a taken DJNZ
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (run && op == 3'd5) cnt <= tgt[CNTW-1:0];
    else if (run && loop_take) cnt <= cnt - CNTW'(1);
`else
  assign loop_take = 1'b0;
`endif
  // next-address selection and stack push/pop/error decode
  always_comb begin
    upc_nxt = upc_inc;
    push = 1'b0;
    pop = 1'b0;
    err = 1'b0;
    case (op)
      3'd1: upc_nxt = tgt;
      3'd2: upc_nxt = t ? tgt : upc_inc;
      3'd3: if (t) begin
        upc_nxt = tgt;
        push = sp != SP_MAX;
        err = sp == SP_MAX;
      end
      3'd4: if (t) begin
        pop = sp != '0;
        err = sp == '0;
        upc_nxt = (sp != '0) ? stk[sp - SPW'(1)] : upc_inc;
      end
      3'd6: upc_nxt = loop_take ? tgt : upc_inc;
      3'd7: upc_nxt = upc;
      default: upc_nxt = upc_inc;
    endcase
  end
  // sequencer state; frozen by hold or once halted
  always_ff @(posedge clk)
    if (reset) begin
      upc <= '0;
      out_sig <= '0;
      sp <= '0;
      halted <= 1'b0;
      stk_err <= 1'b0;
    end else if (run) begin
      upc <= upc_nxt;
      out_sig <= ctrl;
      halted <= op == 3'd7;
      stk_err <= stk_err | err;
      sp <= push ? sp + SPW'(1) : pop ? sp - SPW'(1) : sp;
    end
  // return-address storage; contents need no reset
  always_ff @(posedge clk)
    if (!reset && run && push) stk[sp] <= upc_inc;
endmodule

// File: tb/tb_trisc_useq.sv
// tb_trisc_useq: directed and randomized checks of trisc_useq against a queue-based reference model
`timescale 1ns/1ps
module tb_trisc_useq;
  localparam int SD = 4;
  logic clk = 0, reset = 0, hold = 0, halted, stk_err;
  logic [6:0] cond = 0;
  logic [5:0] rom_addr;
  logic [40:0] rom_data;
  logic [27:0] out_sig;
  logic [40:0] rom [64];
  int n_chk = 0, n_pass = 0;
  int m_pc, m_cnt;
  logic [27:0] m_out;
  bit m_halt, m_err;
  int stk[$];
  int seq[$];

  trisc_useq dut (
    .clk(clk), .reset(reset), .cond(cond), .hold(hold), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_sig(out_sig), .halted(halted), .stk_err(stk_err)
  );

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [40:0] mw(input int c, input int op, input int cs, input int cp, input int tg);
    return {28'(c), 3'(op), 3'(cs), 1'(cp), 6'(tg)};
  endfunction

  task automatic fill_cont();
    for (int i = 0; i < 64; i++) rom[i] = mw('h100 + i, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_pc = 0; m_out = 0; m_cnt = 0; m_halt = 0; m_err = 0;
    stk.delete();
  endtask

  task automatic model_step();
    logic [40:0] w;
    int op, cs, tg, nx;
    bit t;
    w = rom[m_pc];
    if (m_halt || hold) return;
    op = int'(w[12:10]); cs = int'(w[9:7]); tg = int'(w[5:0]);
    t = ((cs == 0) ? 1'b1 : cond[cs-1]) ^ w[6];
    nx = (m_pc + 1) % 64;
    m_out = w[40:13];
    case (op)
      1: nx = tg;
      2: if (t) nx = tg;
      3: if (t) begin
        if (stk.size() == SD) m_err = 1;
        else stk.push_back((m_pc + 1) % 64);
        nx = tg;
      end
      4: if (t) begin
        if (stk.size() == 0) m_err = 1;
        else nx = stk.pop_back();
      end
`ifdef TRISC_USEQ_LOOP_EN
      5: m_cnt = tg;
      6: if (m_cnt != 0) begin m_cnt--; nx = tg; end
`endif
      7: begin nx = m_pc; m_halt = 1; end
      default: ;
    endcase
    m_pc = nx;
  endtask

  task automatic compare_all();
    check("addr", rom_addr, m_pc);
    check("out_sig", out_sig, m_out);
    check("halted", halted, m_halt);
    check("stk_err", stk_err, m_err);
  endtask

  task automatic step(input logic [6:0] c, input logic h);
    cond = c; hold = h;
    model_step();
    @(posedge clk); @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1; hold = 1'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0; hold = 0;
    model_reset();
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    // reset with a ROM of jumps
    for (int i = 0; i < 64; i++) rom[i] = mw('h100 + i, 1, 0, 0, (i + 5) % 64);
    do_reset();
    check("rst_addr", rom_addr, 0);
    check("rst_out", out_sig, 0);
    check("rst_halt", halted, 0);
    check("rst_err", stk_err, 0);
    step(0, 0);
    check("first_ctrl", out_sig, 'h100);
    check("first_jmp", rom_addr, 5);
    // conditional jump on cond[1] with both polarities
    for (int cp = 0; cp < 2; cp++)
      for (int c1 = 0; c1 < 2; c1++) begin
        fill_cont();
        rom[0] = mw('h200, 2, 2, cp, 9);
        do_reset();
        step(7'(($urandom & 'h7D) | (c1 << 1)), 0);
        check("cjmp", rom_addr, ((c1 ^ cp) != 0) ? 9 : 1);
      end
    fill_cont();
    rom[0] = mw('h200, 2, 0, 0, 9);
    do_reset();
    step(7'($urandom), 0);
    check("cjmp_always", rom_addr, 9);
    // call then return, then return on an empty stack
    fill_cont();
    rom[3] = mw('h300, 3, 0, 0, 20);
    rom[20] = mw('h301, 4, 0, 0, 0);
    rom[4] = mw('h302, 4, 0, 0, 0);
    do_reset();
    repeat (3) step(0, 0);
    check("call_at", rom_addr, 3);
    step(0, 0);
    check("call_tgt", rom_addr, 20);
    step(0, 0);
    check("ret_to", rom_addr, 4);
    check("ret_noerr", stk_err, 0);
    step(0, 0);
    check("under_addr", rom_addr, 5);
    check("under_err", stk_err, 1);
    // five nested calls overflow a four-deep stack
    fill_cont();
    for (int i = 0; i < 5; i++) rom[i * 10] = mw('h400 + i, 3, 0, 0, i * 10 + 10);
    rom[50] = mw('h4ff, 4, 0, 0, 0);
    do_reset();
    repeat (4) step(0, 0);
    check("nest4_addr", rom_addr, 40);
    check("nest4_err", stk_err, 0);
    step(0, 0);
    check("over_addr", rom_addr, 50);
    check("over_err", stk_err, 1);
    step(0, 0);
    check("over_ret", rom_addr, 31);
    // counted loop
    fill_cont();
    rom[0] = mw('h500, 5, 0, 0, 3);
    rom[2] = mw('h502, 6, 0, 0, 1);
`ifdef TRISC_USEQ_LOOP_EN
    seq = {0, 1, 2, 1, 2, 1, 2, 1, 2, 3};
`else
    seq = {0, 1, 2, 3};
`endif
    do_reset();
    check("loop_0", rom_addr, seq[0]);
    for (int i = 1; i < seq.size(); i++) begin
      step(7'($urandom), 0);
      check($sformatf("loop_%0d", i), rom_addr, seq[i]);
    end
    // hold freezes, then HALT is sticky until reset
    fill_cont();
    rom[7] = mw('h1ff, 7, 0, 0, 0);
    do_reset();
    repeat (2) step(0, 0);
    repeat (3) begin
      step(7'($urandom), 1);
      check("hold_addr", rom_addr, 2);
      check("hold_out", out_sig, 'h101);
    end
    step(0, 0);
    check("resume_addr", rom_addr, 3);
    check("resume_out", out_sig, 'h102);
    repeat (4) step(0, 0);
    check("pre_halt", rom_addr, 7);
    step(0, 0);
    check("halt_out", out_sig, 'h1ff);
    repeat (3) begin
      step(7'($urandom), 1'($urandom));
      check("halt_addr", rom_addr, 7);
      check("halt_flag", halted, 1);
    end
    do_reset();
    check("halt_clr", halted, 0);
    // address wraps past the top of the ROM
    fill_cont();
    rom[0] = mw('h600, 1, 0, 0, 63);
    do_reset();
    step(0, 0);
    check("at_top", rom_addr, 63);
    step(0, 0);
    check("wrap", rom_addr, 0);
    // random microprograms with random cond, hold and occasional resets
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) begin
        int op;
        op = $urandom_range(0, 7);
        if (op == 7 && $urandom_range(0, 9) != 0) op = 0;
        rom[i] = mw(int'($urandom), op, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 63));
      end
      do_reset();
      for (int s = 0; s < 150; s++) begin
        if ($urandom_range(0, 49) == 0) do_reset();
        else step(7'($urandom), $urandom_range(0, 4) == 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
